// File: rtl/ucaspian_pkg.sv
// ucaspian_pkg: shared command/state encodings and default widths for the uCaspian step controller
package ucaspian_pkg;
  localparam int DEF_NUM_UNITS = 3;
  localparam int DEF_STEP_W = 16;
  localparam int DEF_MASK_CYC = 2;
  localparam int DEF_WDOG_W = 16;
  typedef enum logic [1:0] {
    OP_RUN = 2'd0,
    OP_CLEAR_ACT = 2'd1,
    OP_CLEAR_CFG = 2'd2,
    OP_NOP = 2'd3
  } cmd_op_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PULSE,
    S_MASK,
    S_WAIT,
    S_DONE
  } step_state_t;
endpackage

// File: rtl/ucaspian_wdog.sv
// ucaspian_wdog: loadable up-counter that flags expiry at its all-ones value
module ucaspian_wdog #(
  parameter int WDOG_W = 16
) (
  input logic clk,
  input logic reset_n,
  input logic load,
  input logic en,
  output logic expire
);
  logic [WDOG_W-1:0] cnt;
  assign expire = &cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en && !expire) cnt <= cnt + WDOG_W'(1);
  end
endmodule

// File: rtl/ucaspian_step_ctrl.sv
// ucaspian_step_ctrl: host-command time-step sequencer driving clear/step controls of the uCaspian units
module ucaspian_step_ctrl
  import ucaspian_pkg::*;
#(
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int STEP_W = DEF_STEP_W,
  parameter int MASK_CYC = DEF_MASK_CYC,
  parameter int WDOG_W = DEF_WDOG_W
) (
  input logic clk,
  input logic reset_n,
  input logic [1:0] cmd_op,
  input logic [STEP_W-1:0] cmd_steps,
  input logic cmd_vld,
  output logic cmd_rdy,
  input logic stop_req,
  output logic enable,
  output logic clear_act,
  output logic clear_config,
  input logic [NUM_UNITS-1:0] clear_done_i,
  output logic next_step,
  input logic [NUM_UNITS-1:0] step_done_i,
  output logic [STEP_W-1:0] step_count,
  output logic busy,
  output logic cmd_done,
  output logic timeout
);
  localparam int MW = $clog2(MASK_CYC + 1);
  step_state_t state, state_nxt;
  cmd_op_t op_q;
  logic [STEP_W-1:0] target;
  logic [MW-1:0] mask_cnt;
  logic stop_pend, accept, all_clr, all_step, last, wd_expire, wd_load, wd_en, timeout_set;
  assign accept = cmd_vld && cmd_rdy;
  assign all_clr = &clear_done_i;
  assign all_step = &step_done_i;
  assign last = (step_count + STEP_W'(1)) == target;
  assign cmd_rdy = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign enable = state inside {S_PULSE, S_MASK, S_WAIT};
  assign next_step = state == S_PULSE;
  assign cmd_done = state == S_DONE;
  assign clear_act = state == S_CLEAR && op_q == OP_CLEAR_ACT;
  assign clear_config = state == S_CLEAR && op_q == OP_CLEAR_CFG;
  assign wd_load = state_nxt != state;
  assign wd_en = state inside {S_CLEAR, S_MASK, S_WAIT};
  // a completing handshake wins over a simultaneous watchdog expiry
  assign timeout_set = wd_expire && ((state == S_CLEAR && !all_clr) || state == S_MASK ||
                                     (state == S_WAIT && !all_step));
  ucaspian_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk(clk),
    .reset_n(reset_n),
    .load(wd_load),
    .en(wd_en),
    .expire(wd_expire)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_vld) state_nxt = (cmd_op == OP_CLEAR_ACT || cmd_op == OP_CLEAR_CFG) ? S_CLEAR :
                                      (cmd_op == OP_RUN && cmd_steps != '0) ? S_PULSE : S_DONE;
      S_CLEAR: state_nxt = (all_clr || wd_expire) ? S_DONE : S_CLEAR;
      S_PULSE: state_nxt = S_MASK;
      S_MASK: state_nxt = wd_expire ? S_DONE : (mask_cnt == MW'(MASK_CYC - 1)) ? S_WAIT : S_MASK;
      S_WAIT: state_nxt = all_step ? ((last || stop_pend || stop_req) ? S_DONE : S_PULSE) :
                          wd_expire ? S_DONE : S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= OP_NOP;
      target <= '0;
      step_count <= '0;
      stop_pend <= 1'b0;
      timeout <= 1'b0;
      mask_cnt <= '0;
    end else begin
      mask_cnt <= (state == S_MASK) ? mask_cnt + MW'(1) : '0;
      if (accept) begin
        op_q <= cmd_op_t'(cmd_op);
        target <= cmd_steps;
        step_count <= '0;
        stop_pend <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if (stop_req && !(state inside {S_IDLE, S_CLEAR})) stop_pend <= 1'b1;
        if (state == S_WAIT && all_step) step_count <= step_count + STEP_W'(1);
        if (timeout_set) timeout <= 1'b1;
      end
    end
  end
endmodule
